// File: rtl/prefetch_cache_ram.sv
// Backing RAM with fixed read latency, a direct-mapped register cache and a one-entry sequential prefetcher.
// Optional hit/miss/prefetch counters are enabled by defining PREFETCH_CACHE_STATS_EN.
module prefetch_cache_ram #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  parameter int LINES   = 8,
  parameter int PF_DIST = 8,
  parameter int RD_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData
`ifdef PREFETCH_CACHE_STATS_EN
  ,
  output logic [31:0]       hitCnt,
  output logic [31:0]       missCnt,
  output logic [31:0]       pfCnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAST  = RD_LAT - 1;
  localparam logic [ADDR_W-1:0] PF_OFF = ADDR_W'(PF_DIST);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MISS_ISSUE = 2'd1,
    MISS_WAIT  = 2'd2
  } stateE;

  function automatic logic [IDX_W-1:0] idxOf(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tagOf(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W];
  endfunction

  stateE state, stateNext;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LINES-1:0]  lineValid;
  logic [TAG_W-1:0]  lineTag  [LINES];
  logic [DATA_W-1:0] lineData [LINES];

  logic [RD_LAT-1:0] pipeVld;
  logic [RD_LAT-1:0] pipeKind;
  logic [RD_LAT-1:0] pipeStale;
  logic [ADDR_W-1:0] pipeAddr [RD_LAT];
  logic [DATA_W-1:0] pipeData [RD_LAT];

  logic              pfPending;
  logic [ADDR_W-1:0] pfAddr;
  logic [ADDR_W-1:0] missAddr;

  logic              accept, rdAcc, wrAcc, reqHit;
  logic [IDX_W-1:0]  reqIdx, landIdx;
  logic [ADDR_W-1:0] pfNext, issueAddr, landAddr;
  logic              pfNextHit, demandIssue, pfIssue;
  logic              landStale, landGood, landFill, landMatch, missDone, inflight;

  // Request decode, port arbitration and fill-pipeline lookups
  always_comb begin
    accept      = reqValid && reqReady;
    rdAcc       = accept && !reqWe;
    wrAcc       = accept && reqWe;
    reqIdx      = idxOf(reqAddr);
    reqHit      = lineValid[reqIdx] && (lineTag[reqIdx] == tagOf(reqAddr));
    pfNext      = reqAddr + PF_OFF;
    pfNextHit   = lineValid[idxOf(pfNext)] && (lineTag[idxOf(pfNext)] == tagOf(pfNext));
    demandIssue = (state == MISS_ISSUE);
    pfIssue     = pfPending && !demandIssue && !wrAcc;
    issueAddr   = demandIssue ? missAddr : pfAddr;
    landAddr    = pipeAddr[LAST];
    landIdx     = idxOf(landAddr);
    landStale   = pipeStale[LAST] || (wrAcc && (reqAddr == landAddr));
    landGood    = pipeVld[LAST] && !landStale;
    // A write that hits the same line this cycle beats a landing prefetch
    landFill    = landGood && !(pipeKind[LAST] && wrAcc && reqHit && (reqIdx == landIdx));
    landMatch   = landGood && (landAddr == reqAddr);
    missDone    = (state == MISS_WAIT) && landGood && (landAddr == missAddr);
    inflight    = pfIssue && (pfAddr == reqAddr);
    for (int i = 0; i < LAST; i++) begin
      inflight = inflight || (pipeVld[i] && !pipeStale[i] && (pipeAddr[i] == reqAddr));
    end
  end

  // Next-state logic for the miss handler
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (rdAcc && !reqHit && !landMatch) begin
          stateNext = inflight ? MISS_WAIT : MISS_ISSUE;
        end else begin
          stateNext = IDLE;
        end
      end
      MISS_ISSUE: stateNext = MISS_WAIT;
      MISS_WAIT: begin
        if (missDone) begin
          stateNext = IDLE;
        end else begin
          stateNext = MISS_WAIT;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspData  <= '0;
      missAddr <= '0;
    end else begin
      state    <= stateNext;
      reqReady <= (stateNext == IDLE);
      rspValid <= 1'b0;
      if (rdAcc) begin
        missAddr <= reqAddr;
      end
      if (rdAcc && reqHit) begin
        rspValid <= 1'b1;
        rspData  <= lineData[reqIdx];
      end else if ((rdAcc && landMatch) || missDone) begin
        rspValid <= 1'b1;
        rspData  <= pipeData[LAST];
      end
    end
  end

  // Single-entry prefetch register; a newer read replaces an older pending entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfPending <= 1'b0;
      pfAddr    <= '0;
    end else if (rdAcc) begin
      pfAddr    <= pfNext;
      pfPending <= !pfNextHit;
    end else if (pfIssue) begin
      pfPending <= 1'b0;
    end
  end

  // Read-latency pipeline carrying fill data with its address, kind and stale flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeVld   <= '0;
      pipeKind  <= '0;
      pipeStale <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipeAddr[i] <= '0;
        pipeData[i] <= '0;
      end
    end else begin
      pipeVld[0]   <= demandIssue || pfIssue;
      pipeKind[0]  <= !demandIssue;
      pipeStale[0] <= 1'b0;
      pipeAddr[0]  <= issueAddr;
      pipeData[0]  <= mem[issueAddr];
      for (int i = 1; i < RD_LAT; i++) begin
        pipeVld[i]   <= pipeVld[i-1];
        pipeKind[i]  <= pipeKind[i-1];
        pipeStale[i] <= pipeStale[i-1] || (wrAcc && (pipeAddr[i-1] == reqAddr));
        pipeAddr[i]  <= pipeAddr[i-1];
        pipeData[i]  <= pipeData[i-1];
      end
    end
  end

  // Cache lines: fills allocate, write hits update in place (applied last so they win)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineValid <= '0;
      for (int i = 0; i < LINES; i++) begin
        lineTag[i]  <= '0;
        lineData[i] <= '0;
      end
    end else begin
      if (landFill) begin
        lineValid[landIdx] <= 1'b1;
        lineTag[landIdx]   <= tagOf(landAddr);
        lineData[landIdx]  <= pipeData[LAST];
      end
      if (wrAcc && reqHit) begin
        lineData[reqIdx] <= reqData;
      end
    end
  end

  // Backing RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[reqAddr] <= reqData;
    end
  end

`ifdef PREFETCH_CACHE_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt  <= 32'd0;
      missCnt <= 32'd0;
      pfCnt   <= 32'd0;
    end else begin
      if (rdAcc && reqHit && (hitCnt != 32'hFFFF_FFFF)) begin
        hitCnt <= hitCnt + 32'd1;
      end
      if (rdAcc && !reqHit && (missCnt != 32'hFFFF_FFFF)) begin
        missCnt <= missCnt + 32'd1;
      end
      if (pfIssue && (pfCnt != 32'hFFFF_FFFF)) begin
        pfCnt <= pfCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_cache_ram.sv
// Directed testbench for prefetch_cache_ram (default parameters, RD_LAT=3, PF_DIST=8, LINES=8).
module tb_prefetch_cache_ram;

  localparam int DW = 64;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqWe = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqData = '0;
  logic          reqReady;
  logic          rspValid;
  logic [DW-1:0] rspData;
`ifdef PREFETCH_CACHE_STATS_EN
  logic [31:0]   hitCnt, missCnt, pfCnt;
`endif

  int checkCnt = 0;
  int errCnt   = 0;

  always #5 clk = ~clk;

  prefetch_cache_ram #(
    .DATA_W(DW), .ADDR_W(AW), .LINES(8), .PF_DIST(8), .RD_LAT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWe(reqWe),
    .reqAddr(reqAddr),
    .reqData(reqData),
    .rspValid(rspValid),
    .rspData(rspData)
`ifdef PREFETCH_CACHE_STATS_EN
    ,
    .hitCnt(hitCnt),
    .missCnt(missCnt),
    .pfCnt(pfCnt)
`endif
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic writeReq(input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqAddr  = a;
    reqData  = d;
    tick();
    reqValid = 1'b0;
    reqWe    = 1'b0;
  endtask

  // Issue a read now; expect rspValid exactly lat cycles after acceptance, idle/stalled in between
  task automatic readExpect(input string tag, input logic [AW-1:0] a, input int lat, input logic [DW-1:0] exp);
    int lowCnt;
    checkVal({tag, "_ready"}, reqReady, 1);
    reqValid = 1'b1;
    reqWe    = 1'b0;
    reqAddr  = a;
    tick();
    reqValid = 1'b0;
    lowCnt   = 0;
    for (int i = 1; i < lat; i++) begin
      if (!reqReady && !rspValid) lowCnt++;
      tick();
    end
    checkVal({tag, "_stall"}, lowCnt, lat - 1);
    checkVal({tag, "_rspValid"}, rspValid, 1);
    checkVal({tag, "_rspData"}, rspData, exp);
    checkVal({tag, "_readyAfter"}, reqReady, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    #12;
    checkVal("rst_ready", reqReady, 1);
    checkVal("rst_rspValid", rspValid, 0);
    checkVal("rst_rspData", rspData, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 48; a++) writeReq(AW'(a), 64'h100 + 64'(a));
    writeReq(10'h3FC, 64'h3FC);
    tick();

    // cold miss, prefetch of 11 lands afterwards
    readExpect("cold3", 10'd3, 5, 64'h103);
    repeat (6) tick();
    readExpect("pf11", 10'd11, 1, 64'h10B);
`ifdef PREFETCH_CACHE_STATS_EN
    checkVal("cnt_miss", missCnt, 1);
    checkVal("cnt_hit", hitCnt, 1);
`endif
    // prefetch of 19 issued in this cycle; read it while in flight
    tick();
    readExpect("inflt19", 10'd19, 3, 64'h113);
    readExpect("inflt27", 10'd27, 2, 64'h11B);

    // stale fill at the landing stage
    doReset();
    readExpect("cold5", 10'd5, 5, 64'h105);
    writeReq(10'd13, 64'hDEAD);
    repeat (6) tick();
    readExpect("stale13", 10'd13, 5, 64'hDEAD);
    tick();
    readExpect("hit21", 10'd21, 1, 64'h115);
    // prefetch of 29 goes out this cycle, write lands on it in stage 0
    tick();
    writeReq(10'd29, 64'hBEEF);
    repeat (3) tick();
    readExpect("stale29", 10'd29, 5, 64'hBEEF);
    repeat (2) tick();
    writeReq(10'd37, 64'hCAFE);
    readExpect("wrhit37", 10'd37, 1, 64'hCAFE);

    // prefetch address wraps past the top of memory
    tick();
    readExpect("wrap3fc", 10'h3FC, 5, 64'h3FC);
    tick();
    readExpect("wrap4", 10'd4, 1, 64'h104);

    // reset during MISS_WAIT discards the in-flight fill
    repeat (5) tick();
    reqValid = 1'b1;
    reqWe    = 1'b0;
    reqAddr  = 10'd6;
    tick();
    reqValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkVal("midrst_ready", reqReady, 1);
    checkVal("midrst_rspValid", rspValid, 0);
    checkVal("midrst_rspData", rspData, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rspValid) seen++;
      tick();
    end
    checkVal("midrst_noRsp", seen, 0);
    readExpect("post6", 10'd6, 5, 64'h106);

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/prefetch_cache_ram.md
Name: prefetch_cache_ram

Overview:
- Parametrised on-chip memory model: a backing RAM with a fixed read latency, fronted by a direct-mapped register cache and a one-entry sequential prefetcher.
- Serves the feature-extraction datapath as a stand-in for external DRAM.
- Adds over the previous generation: valid/ready request handshake, hit/miss detection with tags, write-through with stale-fill protection, and configurable widths, depth and latency.

Parameters:
- DATA_W, 64, data word width.
- ADDR_W, 10, word address width; backing RAM holds 2^ADDR_W words.
- LINES, 8, cache lines; power of two, 2..64; index = addr[log2(LINES)-1:0], tag = remaining upper bits.
- PF_DIST, 8, prefetch distance in words.
- RD_LAT, 3, backing RAM read latency in cycles, 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqWe  in  1  1 = write, 0 = read.
- reqAddr  in  ADDR_W  word address.
- reqData  in  DATA_W  write data.
- rspValid  out  1  read data valid; single-cycle pulse, no backpressure.
- rspData  out  DATA_W  read data.

Behaviour:
- Reset (async assert, sync release):
  - All line valid bits cleared.
  - Prefetch register and fill pipeline cleared.
  - FSM = IDLE; reqReady=1; rspValid=0; rspData=0.
  - Backing RAM contents are not cleared.
  - Reset mid-miss or mid-prefetch discards all in-flight fills.
- Backing port: single port, one op per cycle. Priority: demand miss read > accepted write > prefetch read.
  - Read data plus tag {addr, kind, stale} travels a RD_LAT-deep pipeline and is written into the line at addr's index at the end of that cycle.
- Read hit (accepted at T, line valid, tag equal): rspValid=1 at T+1 with the line data. reqReady stays 1, so back-to-back hits give one response per cycle.
- Read miss (accepted at T):
  - FSM IDLE->MISS_ISSUE; reqReady=0 from T+1.
  - T+1: backing read issued; MISS_ISSUE->MISS_WAIT.
  - T+1+RD_LAT: line filled.
  - T+2+RD_LAT: rspValid=1, FSM->IDLE, reqReady=1.
  - With RD_LAT=3: response at T+5.
- Miss to an address already in flight as a prefetch: no new backing read is issued. FSM goes straight to MISS_WAIT and responds the cycle after that fill lands.
- Write (accepted at T): backing RAM written at T; never stalls in IDLE.
  - If the line is valid with a matching tag, the line data is updated at T (no allocate on write miss).
  - Any in-flight fill with the same address is marked stale and not written to the cache.
  - If a fill and a write target the same index in the same cycle, the write wins.
  - No response is generated for writes.
- Prefetch:
  - Each accepted read loads pfAddr = (reqAddr + PF_DIST) mod 2^ADDR_W and sets pfPending, unless that address already hits.
  - A newer read overwrites an older pending prefetch.
  - Issued on the first cycle the port is free; pfPending is then cleared.
  - Prefetch fills overwrite the victim line unconditionally.
- reqReady=0 in MISS_ISSUE and MISS_WAIT; requests are held by the requester.

Optional Feature:
- Macro: PREFETCH_CACHE_STATS_EN.
- Defined: adds outputs hitCnt, missCnt and pfCnt (32 bits each, reset 0, saturating at 2^32-1).
  - hitCnt increments per accepted read hit.
  - missCnt increments per accepted read miss.
  - pfCnt increments per issued prefetch.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write addr 0..15 with data 0x100+addr, then read addr 3 cold -> rspValid 5 cycles after acceptance, rspData=0x103, reqReady low for 4 cycles.
- Read 3, wait 6 cycles, read 11 -> prefetch already filled 11; response next cycle, rspData=0x10B, missCnt unchanged.
- Read 3, then read 11 two cycles later (prefetch in flight) -> no second backing read; response the cycle after the fill, data 0x10B.
- Read 5 (prefetch 13 issued), write 13=0xDEAD on the next cycle, read 13 after 6 cycles -> miss (stale fill dropped), rspData=0xDEAD.
- Read 0x3FC -> prefetch wraps to 0x004; later read 4 hits with 0x104.
- Assert rst_n low during MISS_WAIT -> rspValid=0, reqReady=1 immediately; after release, read of the same address misses and returns the RAM value.
